// File: rtl/uart_tx_pkg.sv
// Shared constants and state encoding for the 8N1 UART transmitter.
// The baud defaults are the same values the programming receiver uses, so both ends of the link agree.
package uart_tx_pkg;

   localparam int DEF_UART_DATA_LENGTH           = 8;
   localparam int DEF_TX_COUNTER_BITWIDTH        = 3;
   localparam int DEF_BAUD_COUNTS_PER_BIT        = 521;  // 10 MHz clk, 19200 baud
   localparam int DEF_BAUD_RATE_COUNTER_BITWIDTH = 10;
   localparam int DEF_FIFO_DEPTH                 = 4;
   localparam int DEF_FIFO_ADDR_WIDTH            = 2;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Small synchronous FIFO holding bytes waiting for the UART transmitter.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module tx_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  wr_i,
   input  logic [WIDTH-1:0]      wr_data_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      head_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [ADDR_WIDTH:0]   count_o
);

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  w_wr_en;
   logic                  w_pop_en;

   // Full is judged on the count before this edge, so a pop on the same edge does not make room.
   assign full_o   = (r_count == (ADDR_WIDTH+1)'(DEPTH));
   assign empty_o  = (r_count == '0);
   assign count_o  = r_count;
   assign head_o   = r_mem[r_rd_ptr];
   assign w_wr_en  = wr_i && !full_o;
   assign w_pop_en = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= wr_data_i;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en)  r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         if (w_pop_en) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         case ({w_wr_en, w_pop_en})
            2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Serial 8N1 UART transmitter: LSB first, one start bit, one stop bit, FIFO-buffered input.
// Handshake: a data_valid_strb_i edge is taken only if ready_o was high before it; otherwise it is dropped and overflow_o latches.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int UART_DATA_LENGTH           = uart_tx_pkg::DEF_UART_DATA_LENGTH,
   parameter int TX_COUNTER_BITWIDTH        = uart_tx_pkg::DEF_TX_COUNTER_BITWIDTH,
   parameter int BAUD_COUNTS_PER_BIT        = uart_tx_pkg::DEF_BAUD_COUNTS_PER_BIT,
   parameter int BAUD_RATE_COUNTER_BITWIDTH = uart_tx_pkg::DEF_BAUD_RATE_COUNTER_BITWIDTH,
   parameter int FIFO_DEPTH                 = uart_tx_pkg::DEF_FIFO_DEPTH,
   parameter int FIFO_ADDR_WIDTH            = uart_tx_pkg::DEF_FIFO_ADDR_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [UART_DATA_LENGTH-1:0] data_i,
   input  logic                        data_valid_strb_i,
   output logic                        ready_o,
   output logic                        tx_o,
   output logic                        busy_o,
   output logic                        overflow_o
);

   tx_state_t                         r_state;
   tx_state_t                         w_state_next;
   logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] r_baud;
   logic [BAUD_RATE_COUNTER_BITWIDTH-1:0] w_baud_next;
   logic [TX_COUNTER_BITWIDTH-1:0]    r_bit;
   logic [TX_COUNTER_BITWIDTH-1:0]    w_bit_next;
   logic [UART_DATA_LENGTH-1:0]       r_shift;
   logic [UART_DATA_LENGTH-1:0]       w_shift_next;
   logic                              r_tx;
   logic                              w_tx_next;
   logic                              r_overflow;
   logic                              w_pop;
   logic                              w_baud_done;
   logic                              w_last_bit;
   logic [UART_DATA_LENGTH-1:0]       w_head;
   logic                              w_full;
   logic                              w_empty;
   logic [FIFO_ADDR_WIDTH:0]          w_count;

   tx_fifo #(
      .WIDTH      (UART_DATA_LENGTH),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .wr_i      (data_valid_strb_i),
      .wr_data_i (data_i),
      .pop_i     (w_pop),
      .head_o    (w_head),
      .full_o    (w_full),
      .empty_o   (w_empty),
      .count_o   (w_count)
   );

   assign w_baud_done = (r_baud == BAUD_RATE_COUNTER_BITWIDTH'(BAUD_COUNTS_PER_BIT - 1));
   assign w_last_bit  = (r_bit == TX_COUNTER_BITWIDTH'(UART_DATA_LENGTH - 1));

   always_comb begin
      w_state_next = r_state;
      w_baud_next  = r_baud;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_pop        = 1'b0;
      w_tx_next    = 1'b1;
      case (r_state)
         TX_IDLE: begin
            w_baud_next = '0;
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_shift_next = w_head;
               w_state_next = TX_START;
            end
         end
         TX_START: begin
            if (w_baud_done) begin
               w_baud_next  = '0;
               w_bit_next   = '0;
               w_state_next = TX_DATA;
            end else begin
               w_baud_next = r_baud + BAUD_RATE_COUNTER_BITWIDTH'(1);
            end
         end
         TX_DATA: begin
            if (w_baud_done) begin
               w_baud_next  = '0;
               w_shift_next = r_shift >> 1;
               if (w_last_bit) w_state_next = TX_STOP;
               else            w_bit_next   = r_bit + TX_COUNTER_BITWIDTH'(1);
            end else begin
               w_baud_next = r_baud + BAUD_RATE_COUNTER_BITWIDTH'(1);
            end
         end
         TX_STOP: begin
            if (w_baud_done) begin
               w_baud_next = '0;
               // Chain straight into the next start bit so queued bytes go out with no idle gap.
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_shift_next = w_head;
                  w_state_next = TX_START;
               end else begin
                  w_state_next = TX_IDLE;
               end
            end else begin
               w_baud_next = r_baud + BAUD_RATE_COUNTER_BITWIDTH'(1);
            end
         end
         default: w_state_next = TX_IDLE;
      endcase
      // The line level is registered from the next state so tx_o comes straight off a flop.
      case (w_state_next)
         TX_START: w_tx_next = 1'b0;
         TX_DATA:  w_tx_next = w_shift_next[0];
         default:  w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state    <= TX_IDLE;
         r_baud     <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_baud  <= w_baud_next;
         r_bit   <= w_bit_next;
         r_shift <= w_shift_next;
         r_tx    <= w_tx_next;
         if (data_valid_strb_i && w_full) r_overflow <= 1'b1;
      end
   end

   assign tx_o       = r_tx;
   assign overflow_o = r_overflow;
   assign ready_o    = !w_full;
   assign busy_o     = (r_state != TX_IDLE) || (w_count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame timing, bit content, back-to-back chaining, overflow, reset abort, loopback.
// A bench-side receiver samples each bit at its midpoint and compares bytes against an expected queue.
module tb_uart_tx;

   localparam int BIT_T    = 521;
   localparam int HALF_T   = 260;
   localparam int FRAME_T  = 5210;
   localparam int BUDGET   = 12000;

   logic       clk_i   = 1'b0;
   logic       reset_i = 1'b0;
   logic       strb    = 1'b0;
   logic [7:0] data_i  = 8'h00;
   logic       ready_o;
   logic       tx_o;
   logic       busy_o;
   logic       overflow_o;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc      = 0;
   logic [7:0] exp_q[$];
   logic [7:0] burst_q[$];

   uart_tx dut (
      .clk_i             (clk_i),
      .reset_i           (reset_i),
      .data_i            (data_i),
      .data_valid_strb_i (strb),
      .ready_o           (ready_o),
      .tx_o              (tx_o),
      .busy_o            (busy_o),
      .overflow_o        (overflow_o)
   );

   // Clock / cycle counter
   always #50 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin
      #(100 * 95000);
      $display("FAIL watchdog: got cycle %0d required finish before 95000", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Driver tasks
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic write_burst(input int n_acc);
      int k;
      k = 0;
      while (burst_q.size() > 0) begin
         data_i = burst_q.pop_front();
         strb   = 1'b1;
         if (k < n_acc) exp_q.push_back(data_i);
         tick();
         k++;
      end
      strb = 1'b0;
   endtask

   task automatic wait_fall(input string tag, output int fall_cyc);
      int n;
      n = 0;
      while (tx_o !== 1'b0 && n < BUDGET) begin
         tick();
         n++;
      end
      check({tag, "_start_seen"}, (n < BUDGET), 1);
      fall_cyc = cyc;
   endtask

   task automatic wait_idle(input string tag, output int idle_cyc);
      int n;
      n = 0;
      while (busy_o !== 1'b0 && n < 2 * BUDGET) begin
         tick();
         n++;
      end
      check({tag, "_idle_seen"}, (n < 2 * BUDGET), 1);
      idle_cyc = cyc;
   endtask

   // Scoreboard receiver: returns mid stop bit, line still high.
   task automatic rx_byte(input string tag, output int fall_cyc);
      logic [7:0] b;
      logic [7:0] e;
      wait_fall(tag, fall_cyc);
      ticks(HALF_T);
      check({tag, "_start_bit"}, tx_o, 0);
      for (int i = 0; i < 8; i++) begin
         ticks(BIT_T);
         b[i] = tx_o;
      end
      ticks(BIT_T);
      check({tag, "_stop_bit"}, tx_o, 1);
      check({tag, "_exp_q_empty"}, (exp_q.size() == 0), 0);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_data"}, b, e);
      end
   endtask

   logic [7:0] t3_data [6];
   int f1, f2, f3, s, idle_c;

   initial begin
      t3_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      // Reset state
      ticks(3);
      check("rst_tx", tx_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_ovf", overflow_o, 0);
      check("rst_ready", ready_o, 1);
      reset_i = 1'b1;
      ticks(2);
      check("idle_tx", tx_o, 1);

      // 1: single byte A5 from IDLE
      exp_q.push_back(8'hA5);
      data_i = 8'hA5;
      strb   = 1'b1;
      tick();
      strb   = 1'b0;
      s      = cyc;
      check("t1_busy_after_strobe", busy_o, 1);
      check("t1_tx_still_high", tx_o, 1);
      rx_byte("t1", f1);
      check("t1_latency", f1 - s, 1);
      wait_idle("t1", idle_c);
      check("t1_busy_span", idle_c - f1, FRAME_T);

      // 2: back-to-back 0F, F0
      ticks(5);
      burst_q = '{8'h0F, 8'hF0};
      write_burst(2);
      rx_byte("t2a", f1);
      rx_byte("t2b", f2);
      check("t2_gap", f2 - f1, FRAME_T);
      wait_idle("t2", idle_c);
      check("t2_busy_span", idle_c - f1, 2 * FRAME_T);

      // 3: overflow with six consecutive strobes while first frame is in START
      ticks(5);
      check("t3_ovf_before", overflow_o, 0);
      for (int k = 0; k < 6; k++) begin
         data_i = t3_data[k];
         strb   = 1'b1;
         if (k < 5) exp_q.push_back(t3_data[k]);
         tick();
         if (k == 3) check("t3_ready_after4", ready_o, 1);
         if (k == 4) check("t3_ready_after5", ready_o, 0);
         if (k == 4) check("t3_ovf_after5", overflow_o, 0);
         if (k == 5) check("t3_ovf_after6", overflow_o, 1);
      end
      strb = 1'b0;
      check("t3_tx_in_start", tx_o, 0);
      for (int k = 0; k < 5; k++) rx_byte("t3", f3);
      check("t3_ovf_held", overflow_o, 1);

      // 4: write on the edge where the last STOP bit ends with the FIFO empty
      while (cyc < f3 + FRAME_T - 1) tick();
      exp_q.push_back(8'h96);
      data_i = 8'h96;
      strb   = 1'b1;
      tick();
      strb   = 1'b0;
      rx_byte("t4", f1);
      wait_idle("t4", idle_c);
      check("t4_ovf_held", overflow_o, 1);
      check("t4_ready", ready_o, 1);

      // 5: reset during DATA bit 3 of 8'h55 with 8'h66 queued
      ticks(5);
      data_i = 8'h55;
      strb   = 1'b1;
      tick();
      data_i = 8'h66;
      tick();
      strb   = 1'b0;
      wait_fall("t5", f1);
      while (cyc < f1 + HALF_T + 4 * BIT_T) tick();
      check("t5_bit3_low", tx_o, 0);
      check("t5_busy_mid", busy_o, 1);
      #10;
      reset_i = 1'b0;
      #1;
      check("t5_rst_tx", tx_o, 1);
      check("t5_rst_busy", busy_o, 0);
      check("t5_rst_ovf", overflow_o, 0);
      check("t5_rst_ready", ready_o, 1);
      ticks(3);
      reset_i = 1'b1;
      ticks(600);
      check("t5_post_tx", tx_o, 1);
      check("t5_post_busy", busy_o, 0);
      exp_q.push_back(8'h3C);
      data_i = 8'h3C;
      strb   = 1'b1;
      tick();
      strb   = 1'b0;
      rx_byte("t5_3c", f1);
      wait_idle("t5", idle_c);

      // 6: loopback of program bytes
      ticks(5);
      burst_q = '{8'hDE, 8'hCF, 8'h4F, 8'hA0};
      write_burst(4);
      for (int k = 0; k < 4; k++) rx_byte("t6", f1);
      wait_idle("t6", idle_c);
      check("t6_queue_drained", exp_q.size(), 0);
      check("t6_ovf", overflow_o, 0);

      // Final report
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
